// File: rtl/shift_ctrl_pkg.sv
// rtl/shift_ctrl_pkg.sv - shared state type and defaults for the shift/load sequencer
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } shift_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/shift_load_ctrl.sv
// rtl/shift_load_ctrl.sv - parallel word to serial shift-register sequencer with latch strobe
// Build option: define LSB_FIRST_EN to serialise LSB-first (default MSB-first).
module shift_load_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int LATCH_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             N_RESET,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             VALID,
  output logic             READY,
  input  logic             CLEAR,
  output logic             SER_OUT,
  output logic             SHIFT_EN,
  output logic             LATCH_STB
);

  // Counter must cover both the bit phase and the strobe phase.
  localparam int CNT_MAX = (WIDTH > LATCH_CYCLES) ? WIDTH : LATCH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);

  shift_state_t     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shadow;
  logic             r_ser;
  logic             r_shift_en;
  logic             r_latch_stb;

  logic             w_first_bit;
  logic [WIDTH-1:0] w_load_rest;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_shadow_next;

  // The first bit goes straight to the output register on accept; the shadow holds the rest.
`ifdef LSB_FIRST_EN
  assign w_first_bit   = DATA_IN[0];
  assign w_load_rest   = DATA_IN >> 1;
  assign w_next_bit    = r_shadow[0];
  assign w_shadow_next = r_shadow >> 1;
`else
  assign w_first_bit   = DATA_IN[WIDTH-1];
  assign w_load_rest   = {DATA_IN[WIDTH-2:0], 1'b0};
  assign w_next_bit    = r_shadow[WIDTH-1];
  assign w_shadow_next = {r_shadow[WIDTH-2:0], 1'b0};
`endif

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shadow    <= '0;
      r_ser       <= 1'b0;
      r_shift_en  <= 1'b0;
      r_latch_stb <= 1'b0;
    end else if (CLEAR) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ser       <= 1'b0;
      r_shift_en  <= 1'b0;
      r_latch_stb <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (VALID) begin
            r_state    <= SHIFT;
            r_cnt      <= '0;
            r_shadow   <= w_load_rest;
            r_ser      <= w_first_bit;
            r_shift_en <= 1'b1;
          end
        end
        SHIFT: begin
          if (r_cnt == SHIFT_LAST) begin
            r_state     <= LATCH;
            r_cnt       <= '0;
            r_ser       <= 1'b0;
            r_shift_en  <= 1'b0;
            r_latch_stb <= 1'b1;
          end else begin
            r_cnt    <= r_cnt + 1'b1;
            r_ser    <= w_next_bit;
            r_shadow <= w_shadow_next;
          end
        end
        LATCH: begin
          if (r_cnt == LATCH_LAST) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_latch_stb <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_ser       <= 1'b0;
          r_shift_en  <= 1'b0;
          r_latch_stb <= 1'b0;
        end
      endcase
    end
  end

  assign READY     = (r_state == IDLE);
  assign SER_OUT   = r_ser;
  assign SHIFT_EN  = r_shift_en;
  assign LATCH_STB = r_latch_stb;

endmodule

// File: tb/tb_shift_load_ctrl.sv
// tb/tb_shift_load_ctrl.sv - directed bench: controller driving a cascaded DFF shift register
module tb_shift_load_ctrl;

  logic       CLK = 1'b0;
  logic       N_RESET;
  logic [7:0] DATA_IN;
  logic       VALID;
  logic       READY;
  logic       CLEAR;
  logic       SER_OUT;
  logic       SHIFT_EN;
  logic       LATCH_STB;

  int n_vec = 0;
  int n_err = 0;

  // Bit order as seen on SER_OUT for 8'hAD, first bit in [7]; Q at strobe.
`ifdef LSB_FIRST_EN
  localparam logic [7:0] SEQ_AD = 8'b1011_0101;
  localparam logic [7:0] Q_AD   = 8'hB5;
`else
  localparam logic [7:0] SEQ_AD = 8'b1010_1101;
  localparam logic [7:0] Q_AD   = 8'hAD;
`endif

  logic [7:0] q = 8'h00;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (SHIFT_EN) q <= {q[6:0], SER_OUT};
  end

  shift_load_ctrl #(.WIDTH(8), .LATCH_CYCLES(1)) dut (
    .CLK      (CLK),
    .N_RESET  (N_RESET),
    .DATA_IN  (DATA_IN),
    .VALID    (VALID),
    .READY    (READY),
    .CLEAR    (CLEAR),
    .SER_OUT  (SER_OUT),
    .SHIFT_EN (SHIFT_EN),
    .LATCH_STB(LATCH_STB)
  );

  task automatic test_reset();
    N_RESET = 1'b0; VALID = 1'b1; DATA_IN = 8'hFF; CLEAR = 1'b0;
    repeat (3) @(negedge CLK);
    n_vec++; if (READY !== 1'b1)     begin n_err++; $display("FAIL reset_ready got %b want 1", READY); end
    n_vec++; if (SHIFT_EN !== 1'b0)  begin n_err++; $display("FAIL reset_shift_en got %b want 0", SHIFT_EN); end
    n_vec++; if (SER_OUT !== 1'b0)   begin n_err++; $display("FAIL reset_ser_out got %b want 0", SER_OUT); end
    n_vec++; if (LATCH_STB !== 1'b0) begin n_err++; $display("FAIL reset_latch_stb got %b want 0", LATCH_STB); end
    VALID = 1'b0;
    N_RESET = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_single_word();
    VALID = 1'b1; DATA_IN = 8'hAD;
    @(negedge CLK);
    VALID = 1'b0;
    n_vec++; if (READY !== 1'b0) begin n_err++; $display("FAIL single_ready_busy got %b want 0", READY); end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge CLK);
      n_vec++;
      if (SHIFT_EN !== 1'b1 || SER_OUT !== SEQ_AD[7-i]) begin
        n_err++;
        $display("FAIL single_bit%0d got en=%b ser=%b want en=1 ser=%b", i, SHIFT_EN, SER_OUT, SEQ_AD[7-i]);
      end
    end
    @(negedge CLK);
    n_vec++; if (LATCH_STB !== 1'b1 || SHIFT_EN !== 1'b0) begin
      n_err++; $display("FAIL single_strobe got stb=%b en=%b want 1/0", LATCH_STB, SHIFT_EN); end
    n_vec++; if (q !== Q_AD) begin n_err++; $display("FAIL single_q got %h want %h", q, Q_AD); end
    @(negedge CLK);
    n_vec++; if (LATCH_STB !== 1'b0 || READY !== 1'b1) begin
      n_err++; $display("FAIL single_ready_return got stb=%b rdy=%b want 0/1", LATCH_STB, READY); end
  endtask

  task automatic test_back_to_back();
    int gap;
    int strobes;
    logic done;
    VALID = 1'b1; DATA_IN = 8'hAD;
    @(negedge CLK);
    DATA_IN = 8'h5A;
    gap = 1; strobes = 0; done = 1'b0;
    while (!done && gap < 30) begin
      if (LATCH_STB === 1'b1) begin
        strobes++;
        n_vec++; if (q !== Q_AD) begin n_err++; $display("FAIL b2b_first_q got %h want %h", q, Q_AD); end
      end
      if (READY === 1'b1) done = 1'b1;
      else begin
        @(negedge CLK);
        gap++;
      end
    end
    n_vec++; if (gap !== 10) begin n_err++; $display("FAIL b2b_period got %0d want 10", gap); end
    n_vec++; if (strobes !== 1) begin n_err++; $display("FAIL b2b_first_strobes got %0d want 1", strobes); end
    @(negedge CLK);
    VALID = 1'b0;
    strobes = 0;
    for (int i = 0; i < 12 && strobes == 0; i++) begin
      if (LATCH_STB === 1'b1) begin
        strobes++;
        n_vec++; if (q !== 8'h5A) begin n_err++; $display("FAIL b2b_second_q got %h want 5a", q); end
      end
      else @(negedge CLK);
    end
    n_vec++; if (strobes !== 1) begin n_err++; $display("FAIL b2b_second_strobe got %0d want 1", strobes); end
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_clear();
    int strobes;
    VALID = 1'b1; DATA_IN = 8'hFF;
    @(negedge CLK);
    VALID = 1'b0;
    repeat (3) @(negedge CLK);
    n_vec++; if (SHIFT_EN !== 1'b1) begin n_err++; $display("FAIL clear_4th_bit_en got %b want 1", SHIFT_EN); end
    CLEAR = 1'b1;
    @(negedge CLK);
    CLEAR = 1'b0;
    n_vec++; if (SHIFT_EN !== 1'b0 || SER_OUT !== 1'b0) begin
      n_err++; $display("FAIL clear_outputs got en=%b ser=%b want 0/0", SHIFT_EN, SER_OUT); end
    n_vec++; if (READY !== 1'b1) begin n_err++; $display("FAIL clear_ready got %b want 1", READY); end
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      if (LATCH_STB === 1'b1) strobes++;
      @(negedge CLK);
    end
    n_vec++; if (strobes !== 0) begin n_err++; $display("FAIL clear_no_strobe got %0d want 0", strobes); end
    // CLEAR with VALID in IDLE: word must be refused.
    CLEAR = 1'b1; VALID = 1'b1; DATA_IN = 8'h3C;
    @(negedge CLK);
    CLEAR = 1'b0; VALID = 1'b0;
    n_vec++; if (READY !== 1'b1 || SHIFT_EN !== 1'b0) begin
      n_err++; $display("FAIL clear_wins_idle got rdy=%b en=%b want 1/0", READY, SHIFT_EN); end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_shift();
    VALID = 1'b1; DATA_IN = 8'hF0;
    @(negedge CLK);
    VALID = 1'b0;
    repeat (2) @(negedge CLK);
    #2;
    N_RESET = 1'b0;
    #1;
    n_vec++; if (SHIFT_EN !== 1'b0 || SER_OUT !== 1'b0 || LATCH_STB !== 1'b0 || READY !== 1'b1) begin
      n_err++; $display("FAIL async_reset got en=%b ser=%b stb=%b rdy=%b want 0/0/0/1",
                        SHIFT_EN, SER_OUT, LATCH_STB, READY); end
    @(negedge CLK);
    N_RESET = 1'b1;
    @(negedge CLK);
    VALID = 1'b1; DATA_IN = 8'h81;
    @(negedge CLK);
    VALID = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge CLK);
      n_vec++;
      if (SHIFT_EN !== 1'b1 || SER_OUT !== ((i == 0 || i == 7) ? 1'b1 : 1'b0)) begin
        n_err++; $display("FAIL post_reset_bit%0d got en=%b ser=%b", i, SHIFT_EN, SER_OUT);
      end
    end
    @(negedge CLK);
    n_vec++; if (LATCH_STB !== 1'b1 || q !== 8'h81) begin
      n_err++; $display("FAIL post_reset_q got stb=%b q=%h want 1/81", LATCH_STB, q); end
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_data_toggle();
    VALID = 1'b1; DATA_IN = 8'hC3;
    @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      DATA_IN = ~DATA_IN ^ 8'(i);
      VALID = ~VALID;
      @(negedge CLK);
    end
    VALID = 1'b0;
    n_vec++; if (LATCH_STB !== 1'b1 || q !== 8'hC3) begin
      n_err++; $display("FAIL toggle_q got stb=%b q=%h want 1/c3", LATCH_STB, q); end
    @(negedge CLK);
    n_vec++; if (READY !== 1'b1 || SHIFT_EN !== 1'b0) begin
      n_err++; $display("FAIL toggle_idle got rdy=%b en=%b want 1/0", READY, SHIFT_EN); end
  endtask

  initial begin
    N_RESET = 1'b0; VALID = 1'b0; DATA_IN = 8'h00; CLEAR = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_clear();
    test_reset_mid_shift();
    test_data_toggle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
